proj1_alu_seq: RTL and testbench
================================

Name: proj1_alu_seq

Overview:
Instruction sequencer that owns an 8-entry x 8-bit register file and a C/Z/N status register, and drives proj1_alu.
- Accepts one instruction at a time through a valid/ready handshake and reads Rd/Rr from the register file.
- Presents the operands, opcode and carry to the ALU, waits the ALU latency, then writes the result and flags back.
- Sits between the instruction source (bench or future fetch unit) and proj1_alu.

Parameters:
ALU_LAT, 1, cycles from ALU inputs registered to alu_data_o/flags valid; legal 1..4
NREG, 8, register file depth; fixed power of two, index width $clog2(NREG)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept instruction
instr_opcode  in  8  ALU opcode encoding (0000xxss shifts, 0100 mult, 1000 and, 1001 or, 1010 xor, 1011 neg, 1100 add, 1101 addc, 1110 sub, 1111 subc)
instr_rd  in  3  destination/first-operand register
instr_rr  in  3  second-operand register
ld_en  in  1  direct register load strobe
ld_addr  in  3  load register index
ld_data  in  8  load value
rd_addr  in  3  debug read index
rd_data  out  8  regs[rd_addr], combinational
alu_data_rd  out  8  operand Rd to ALU
alu_data_rr  out  8  operand Rr to ALU
alu_ci  out  1  carry in to ALU (= status C)
alu_opcode  out  8  opcode to ALU
alu_data_o  in  16  ALU result
alu_co, alu_zo, alu_no  in  1 each  ALU flags
done  out  1  one-cycle pulse, instruction retired
flags  out  3  status {C,Z,N}

Behaviour:
- Reset: state=IDLE, all regs=0, flags=0, done=0, alu_* outputs=0, instr_ready=0 during rst and 1 the cycle after.
- Reset mid-operation abandons the instruction: no writeback, no done pulse.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = !ld_en.
  - ld_en writes regs[ld_addr]<=ld_data and takes priority; no accept in that cycle.
  - Accept on instr_valid && instr_ready: latch rd/opcode, register alu_data_rd=regs[rd], alu_data_rr=regs[rr], alu_ci=C, alu_opcode=opcode; go to EXEC with cnt=ALU_LAT-1.
- EXEC:
  - ALU inputs held stable.
  - cnt decrements; at cnt==0 go to WB.
  - instr_ready=0; ld_en ignored.
- WB (one cycle):
  - Sample alu_data_o and alu_co/zo/no; done=1; write at end of cycle; go to IDLE.
  - Non-mult ops: regs[rd]<=alu_data_o[7:0].
  - Mult (opcode[7:4]==0100): regs[rd]<=alu_data_o[7:0], regs[(rd+1) mod 8]<=alu_data_o[15:8]; rd=7 wraps to r0.
  - All opcodes: flags<={alu_co,alu_zo,alu_no}. The ALU defines flag semantics; the sequencer does not mask them.
- Timing:
  - Accept edge E0; done high in the cycle starting ALU_LAT+1 edges after E0.
  - New results visible on rd_data and flags the cycle after done.
  - Next accept is possible in the cycle after done, giving throughput of one instruction per ALU_LAT+2 cycles.
- rd==rr is legal; both operands read the same pre-instruction value.
- instr_valid may drop without being accepted; no state change.
- Undefined opcode bits (the xx fields) are passed through unchanged.

Decomposition:
- proj1_pkg holds:
  - state_t enum {IDLE,EXEC,WB}
  - opcode-class constants (OP_SHIFT=4'b0000, OP_MULT=4'b0100, OP_AND..OP_SUBC)
  - flag index constants C_BIT=2, Z_BIT=1, N_BIT=0
  - NREG
- One natural sub-module: proj1_regfile. It has 8x8 storage, two combinational read ports (operand, debug) and two write ports (low, high for mult), with write-port-0 priority on an address collision.
- The FSM stays in proj1_alu_seq.

Test Plan:
- Load r1=0x24, r2=0x22; add rd=1 rr=2 (8'b11000000) -> done exactly ALU_LAT+1 cycles after accept, r1=0x46, flags C=0 Z=0 N=0.
- Load r3=0x04, r4=0x04; mult rd=3 rr=4 -> r3=0x10, r4=0x00. Load r7=0x10, r0=0x10; mult rd=7 rr=0 -> r7=0x00, r0=0x01 (wrap).
- Load r5=0x24, r6=0x24; sub rd=5 rr=6 -> r5=0x00, Z=1. Repeat with ld_en asserted together with instr_valid -> load wins, instr_ready=0 that cycle, instruction accepted next cycle.
- Set C=1 via an add of 0xFF+0x01 (r=0x00, C=1, Z=1); then addc of 0x22+0x24 -> alu_ci=1 observed, result 0x47.
- Assert rst during EXEC -> no done pulse, all regs 0, flags 0, instr_ready=1 the cycle after rst deasserts.
- instr_valid held for back-to-back instructions -> instr_ready low from accept through WB, second accept the cycle after done, no dropped or duplicated instruction.

Source files
------------

// File: rtl/proj1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proj1_pkg: shared types and constants for the ALU sequencer slice     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package proj1_pkg;

  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_SHIFT = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NEG   = 4'b1011;
  localparam logic [3:0] OP_ADD   = 4'b1100;
  localparam logic [3:0] OP_ADDC  = 4'b1101;
  localparam logic [3:0] OP_SUB   = 4'b1110;
  localparam logic [3:0] OP_SUBC  = 4'b1111;

  localparam int C_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int N_BIT = 0;

  function automatic logic is_mult(input logic [7:0] op);
    return op[7:4] == OP_MULT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/proj1_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proj1_regfile: NREG x 8 storage, operand/debug reads, two write ports |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module proj1_regfile
  import proj1_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [7:0]    wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [7:0]    wdata1,
  input  logic [AW-1:0] op_rd_addr,
  output logic [7:0]    op_rd_data,
  input  logic [AW-1:0] op_rr_addr,
  output logic [7:0]    op_rr_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  logic [7:0] mem_q [NREG];
  logic [7:0] mem_d [NREG];

  // Port 0 is applied last so it wins when both ports hit the same entry.
  always_comb begin
    mem_d = mem_q;
    if (we1) mem_d[waddr1] = wdata1;
    if (we0) mem_d[waddr0] = wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= 8'h00;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign op_rd_data = mem_q[op_rd_addr];
  assign op_rr_data = mem_q[op_rr_addr];
  assign dbg_data   = mem_q[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/proj1_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proj1_alu_seq: single-issue sequencer feeding proj1_alu, with regfile |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module proj1_alu_seq
  import proj1_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  instr_opcode,
  input  logic [2:0]  instr_rd,
  input  logic [2:0]  instr_rr,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [7:0]  alu_data_rd,
  output logic [7:0]  alu_data_rr,
  output logic        alu_ci,
  output logic [7:0]  alu_opcode,
  input  logic [15:0] alu_data_o,
  input  logic        alu_co,
  input  logic        alu_zo,
  input  logic        alu_no,
  output logic        done,
  output logic [2:0]  flags
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  rd_q, rd_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  alu_rd_q, alu_rd_d;
  logic [7:0]  alu_rr_q, alu_rr_d;
  logic        alu_ci_q, alu_ci_d;
  logic        done_q, done_d;
  logic [2:0]  flags_q, flags_d;

  logic        we0, we1;
  logic [2:0]  waddr0, waddr1;
  logic [7:0]  wdata0, wdata1;
  logic [7:0]  op_rd_data, op_rr_data;

  proj1_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we0        (we0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .we1        (we1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .op_rd_addr (instr_rd),
    .op_rd_data (op_rd_data),
    .op_rr_addr (instr_rr),
    .op_rr_data (op_rr_data),
    .dbg_addr   (rd_addr),
    .dbg_data   (rd_data)
  );

  assign instr_ready = !rst && (state_q == IDLE) && !ld_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    op_d     = op_q;
    alu_rd_d = alu_rd_q;
    alu_rr_d = alu_rr_q;
    alu_ci_d = alu_ci_q;
    done_d   = 1'b0;
    flags_d  = flags_q;
    we0      = 1'b0;
    waddr0   = ld_addr;
    wdata0   = ld_data;
    we1      = 1'b0;
    waddr1   = rd_q + 3'd1;
    wdata1   = alu_data_o[15:8];
    case (state_q)
      IDLE: begin
        if (ld_en) begin
          we0 = 1'b1;
        end else if (instr_valid) begin
          rd_d     = instr_rd;
          op_d     = instr_opcode;
          alu_rd_d = op_rd_data;
          alu_rr_d = op_rr_data;
          alu_ci_d = flags_q[C_BIT];
          cnt_d    = 2'(ALU_LAT - 1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // done is registered, so raise it on the way into WB.
        if (cnt_q == 2'd0) begin
          state_d = WB;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WB: begin
        we0    = 1'b1;
        waddr0 = rd_q;
        wdata0 = alu_data_o[7:0];
        we1    = is_mult(op_q);
        flags_d[C_BIT] = alu_co;
        flags_d[Z_BIT] = alu_zo;
        flags_d[N_BIT] = alu_no;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      rd_q     <= 3'd0;
      op_q     <= 8'h00;
      alu_rd_q <= 8'h00;
      alu_rr_q <= 8'h00;
      alu_ci_q <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      op_q     <= op_d;
      alu_rd_q <= alu_rd_d;
      alu_rr_q <= alu_rr_d;
      alu_ci_q <= alu_ci_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  assign alu_data_rd = alu_rd_q;
  assign alu_data_rr = alu_rr_q;
  assign alu_ci      = alu_ci_q;
  assign alu_opcode  = op_q;
  assign done        = done_q;
  assign flags       = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_proj1_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_proj1_alu_seq: vector table plus load/reset/back-to-back sequences |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_proj1_alu_seq;

  localparam int ALU_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  instr_opcode = 8'h00;
  logic [2:0]  instr_rd = 3'd0;
  logic [2:0]  instr_rr = 3'd0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = 3'd0;
  logic [7:0]  ld_data = 8'h00;
  logic [2:0]  rd_addr = 3'd0;
  logic [7:0]  rd_data;
  logic [7:0]  alu_data_rd, alu_data_rr, alu_opcode;
  logic        alu_ci;
  logic [15:0] alu_data_o;
  logic        alu_co, alu_zo, alu_no;
  logic        done;
  logic [2:0]  flags;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  proj1_alu_seq #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rd(instr_rd), .instr_rr(instr_rr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_data_rd(alu_data_rd), .alu_data_rr(alu_data_rr),
    .alu_ci(alu_ci), .alu_opcode(alu_opcode),
    .alu_data_o(alu_data_o), .alu_co(alu_co), .alu_zo(alu_zo), .alu_no(alu_no),
    .done(done), .flags(flags)
  );

  // ALU stand-in: result is garbage until inputs have been stable ALU_LAT cycles.
  function automatic logic [18:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    logic [15:0] r;
    logic [8:0]  s;
    logic        c, z, n;
    r = 16'h0;
    s = 9'h0;
    c = ci;
    case (op[7:4])
      4'b0000: begin r = {8'h00, op[0] ? {1'b0, a[7:1]} : {a[6:0], 1'b0}}; c = op[0] ? a[0] : a[7]; end
      4'b0100: begin r = 16'(a) * 16'(b); c = r[15]; end
      4'b1000: r = {8'h00, a & b};
      4'b1001: r = {8'h00, a | b};
      4'b1010: r = {8'h00, a ^ b};
      4'b1011: begin s = 9'h000 - {1'b0, a}; r = {8'h00, s[7:0]}; c = (a != 8'h00); end
      4'b1100: begin s = {1'b0, a} + {1'b0, b}; r = {8'h00, s[7:0]}; c = s[8]; end
      4'b1101: begin s = {1'b0, a} + {1'b0, b} + {8'h00, ci}; r = {8'h00, s[7:0]}; c = s[8]; end
      4'b1110: begin s = {1'b0, a} - {1'b0, b}; r = {8'h00, s[7:0]}; c = s[8]; end
      4'b1111: begin s = {1'b0, a} - {1'b0, b} - {8'h00, ci}; r = {8'h00, s[7:0]}; c = s[8]; end
      default: r = 16'h0;
    endcase
    z = (op[7:4] == 4'b0100) ? (r == 16'h0) : (r[7:0] == 8'h00);
    n = (op[7:4] == 4'b0100) ? 1'b0 : r[7];
    return {c, z, n, r};
  endfunction

  logic [7:0]  p_op = 8'h00, p_a = 8'h00, p_b = 8'h00;
  logic        p_ci = 1'b0;
  int          age = 0;
  logic [18:0] alu_res;

  always @(negedge clk) begin
    if ({alu_opcode, alu_data_rd, alu_data_rr, alu_ci} != {p_op, p_a, p_b, p_ci}) begin
      age  <= 0;
      p_op <= alu_opcode; p_a <= alu_data_rd; p_b <= alu_data_rr; p_ci <= alu_ci;
    end else if (age < 100) begin
      age <= age + 1;
    end
  end

  always_comb begin
    alu_res = alu_f(alu_opcode, alu_data_rd, alu_data_rr, alu_ci);
    if (age < ALU_LAT) alu_res = {3'b111, 16'hA5A5};
  end
  assign alu_data_o = alu_res[15:0];
  assign alu_co     = alu_res[18];
  assign alu_zo     = alu_res[17];
  assign alu_no     = alu_res[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    #1;
    while (!done && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rr, output int lat);
    int w;
    @(negedge clk);
    instr_opcode = op; instr_rd = rd; instr_rr = rr; instr_valid = 1'b1;
    w = 0;
    #1;
    while (!instr_ready && w < 10) begin
      @(negedge clk); #1;
      w++;
    end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_done(lat);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [2:0] rd;
    logic [2:0] rr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       ci;
    logic [2:0] fl;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  initial begin
    int lat;
    logic [2:0] ra;
    int n_acc, n_done, acc2, done1;
    logic busy, busy_bad, seen_done;

    //          op     rd    rr    a      b      lo     hi     ci    {C,Z,N}
    vt[0]  = '{8'hC0, 3'd1, 3'd2, 8'h24, 8'h22, 8'h46, 8'h00, 1'b0, 3'b000};
    vt[1]  = '{8'h40, 3'd3, 3'd4, 8'h04, 8'h04, 8'h10, 8'h00, 1'b0, 3'b000};
    vt[2]  = '{8'h40, 3'd7, 3'd0, 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 3'b000};
    vt[3]  = '{8'hE0, 3'd5, 3'd6, 8'h24, 8'h24, 8'h00, 8'h00, 1'b0, 3'b010};
    vt[4]  = '{8'hC0, 3'd1, 3'd2, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 3'b110};
    vt[5]  = '{8'hD0, 3'd1, 3'd2, 8'h22, 8'h24, 8'h47, 8'h00, 1'b1, 3'b000};
    vt[6]  = '{8'h80, 3'd2, 3'd2, 8'hF0, 8'hF0, 8'hF0, 8'h00, 1'b0, 3'b001};
    vt[7]  = '{8'hA0, 3'd3, 3'd3, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0, 3'b010};
    vt[8]  = '{8'hE0, 3'd4, 3'd5, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b0, 3'b101};
    vt[9]  = '{8'hF0, 3'd4, 3'd5, 8'h30, 8'h10, 8'h1F, 8'h00, 1'b1, 3'b000};
    vt[10] = '{8'h96, 3'd6, 3'd7, 8'h0F, 8'h30, 8'h3F, 8'h00, 1'b0, 3'b000};
    vt[11] = '{8'hB0, 3'd0, 3'd1, 8'h01, 8'h00, 8'hFF, 8'h00, 1'b0, 3'b101};
    vt[12] = '{8'h40, 3'd2, 3'd3, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 3'b100};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_alu_op", 32'(alu_opcode), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r); #1;
      chk("rst_reg", 32'(rd_data), 32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      load(vt[i].rd, vt[i].a);
      if (vt[i].rd != vt[i].rr) load(vt[i].rr, vt[i].b);
      issue(vt[i].op, vt[i].rd, vt[i].rr, lat);
      chk("latency", 32'(lat), 32'(ALU_LAT + 1));
      chk("alu_ci", 32'(alu_ci), 32'(vt[i].ci));
      chk("alu_opcode", 32'(alu_opcode), 32'(vt[i].op));
      chk("alu_rd", 32'(alu_data_rd), 32'(vt[i].a));
      chk("alu_rr", 32'(alu_data_rr), 32'(vt[i].b));
      @(negedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
      rd_addr = vt[i].rd; #1;
      chk("result_lo", 32'(rd_data), 32'(vt[i].lo));
      if (vt[i].op[7:4] == 4'b0100) begin
        ra = vt[i].rd + 3'd1;
        rd_addr = ra; #1;
        chk("result_hi", 32'(rd_data), 32'(vt[i].hi));
      end
      chk("flags", 32'(flags), 32'(vt[i].fl));
    end

    // Load and instruction offered together: load wins, accept follows.
    load(3'd5, 8'h11);
    load(3'd6, 8'h24);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 8'h24;
    instr_opcode = 8'hE0; instr_rd = 3'd5; instr_rr = 3'd6; instr_valid = 1'b1;
    #1;
    chk("ld_blocks_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b0; #1;
    chk("ready_after_ld", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_done(lat);
    chk("ld_col_latency", 32'(lat), 32'(ALU_LAT + 1));
    @(negedge clk);
    rd_addr = 3'd5; #1;
    chk("ld_col_result", 32'(rd_data), 32'h00);
    chk("ld_col_flags", 32'(flags), 32'b010);

    // Reset in the middle of EXEC.
    load(3'd1, 8'h05);
    load(3'd2, 8'h06);
    @(negedge clk);
    instr_opcode = 8'hC0; instr_rd = 3'd1; instr_rr = 3'd2; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      if (done) seen_done = 1'b1;
      chk("mid_rst_ready", 32'(instr_ready), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_ready_after", 32'(instr_ready), 32'd1);
    repeat (ALU_LAT + 3) begin
      @(negedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen_done), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r); #1;
      chk("mid_rst_reg", 32'(rd_data), 32'd0);
    end

    // Back-to-back with instr_valid held: r1 = 1+2 = 3, then r1 = 3+3 = 6.
    load(3'd1, 8'h01);
    load(3'd2, 8'h02);
    load(3'd3, 8'h03);
    n_acc = 0; n_done = 0; acc2 = -1; done1 = -1;
    busy = 1'b0; busy_bad = 1'b0;
    @(negedge clk);
    instr_opcode = 8'hC0; instr_rd = 3'd1; instr_rr = 3'd2; instr_valid = 1'b1;
    for (int cyc = 0; cyc < 4 * (ALU_LAT + 2); cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (n_acc == 1) instr_rr = 3'd3;
      if (n_acc == 2) instr_valid = 1'b0;
      #1;
      if (busy && instr_ready) busy_bad = 1'b1;
      if (done) begin
        n_done++;
        if (n_done == 1) done1 = cyc;
        busy = 1'b0;
      end else if (instr_valid && instr_ready) begin
        n_acc++;
        if (n_acc == 2) acc2 = cyc;
        busy = 1'b1;
      end
    end
    chk("b2b_accepts", 32'(n_acc), 32'd2);
    chk("b2b_dones", 32'(n_done), 32'd2);
    chk("b2b_accept_after_done", 32'(acc2), 32'(done1 + 1));
    chk("b2b_ready_low_busy", 32'(busy_bad), 32'd0);
    rd_addr = 3'd1; #1;
    chk("b2b_result", 32'(rd_data), 32'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
